// File: rtl/fpu_add_sub.sv
// fpu_add_sub: IEEE-754 binary32 adder/subtractor with a single registered
// output stage. The result and out_valid appear one clock after in_valid.
// Build option FPU_RNE_EN selects round-to-nearest-even. When it is not
// defined, results are truncated toward zero.
module fpu_add_sub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        Add_nSub,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        out_valid
);

  logic [31:0]       result_q, result_d;
  logic              out_valid_q, out_valid_d;

  logic [31:0]       calc;
  logic              sa, sb;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic [26:0]       xa, xb;
  logic              a_big;
  logic              s_big, s_sml;
  logic [7:0]        e_big, e_sml, e_diff;
  logic [26:0]       x_big, x_sml, x_aln;
  logic [4:0]        sh;
  logic [53:0]       wide;
  logic [27:0]       sum;
  logic [4:0]        lzc;
  logic              lz_found;
  logic [26:0]       norm;
  logic signed [9:0] e_norm, e_fin;
  logic              round_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac;

  // Full add/sub datapath: classify, align, add, normalise, round, special cases.
  always_comb begin
    sa    = A[31];
    sb    = B[31] ^ Add_nSub;
    ea    = A[30:23];
    eb    = B[30:23];
    a_nan = (&ea) && (|A[22:0]);
    b_nan = (&eb) && (|B[22:0]);
    a_inf = (&ea) && !(|A[22:0]);
    b_inf = (&eb) && !(|B[22:0]);

    // Subnormals are flushed to zero: with exponent 0 both the hidden bit
    // and the fraction vanish, so the operand contributes nothing.
    fa = (ea == 8'd0) ? '0 : A[22:0];
    fb = (eb == 8'd0) ? '0 : B[22:0];
    xa = {|ea, fa, 3'b000};
    xb = {|eb, fb, 3'b000};

    a_big = {ea, fa} >= {eb, fb};
    s_big = a_big ? sa : sb;
    s_sml = a_big ? sb : sa;
    e_big = a_big ? ea : eb;
    e_sml = a_big ? eb : ea;
    x_big = a_big ? xa : xb;
    x_sml = a_big ? xb : xa;

    // Clamping the shift at 27 pushes every bit into the sticky field.
    e_diff = e_big - e_sml;
    sh     = (e_diff > 8'd27) ? 5'd27 : e_diff[4:0];
    wide   = {x_sml, 27'b0} >> sh;
    x_aln  = wide[53:27] | {26'b0, |wide[26:0]};

    if (s_big == s_sml) begin
      sum = {1'b0, x_big} + {1'b0, x_aln};
    end else begin
      sum = {1'b0, x_big} - {1'b0, x_aln};
    end

    lzc      = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!lz_found) begin
        if (sum[26 - i]) begin
          lz_found = 1'b1;
        end else begin
          lzc = lzc + 5'd1;
        end
      end
    end

    if (sum[27]) begin
      norm   = sum[27:1] | {26'b0, sum[0]};
      e_norm = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      norm   = sum[26:0] << lzc;
      e_norm = $signed({2'b00, e_big}) - $signed({5'b00000, lzc});
    end

`ifdef FPU_RNE_EN
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
    round_up = 1'b0;
`endif

    mant_r = {1'b0, norm[26:3]} + {24'b0, round_up};
    if (mant_r[24]) begin
      e_fin = e_norm + 10'sd1;
      frac  = mant_r[23:1];
    end else begin
      e_fin = e_norm;
      frac  = mant_r[22:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      calc = 32'h7FC0_0000;
    end else if (a_inf) begin
      calc = {sa, 8'hFF, 23'b0};
    end else if (b_inf) begin
      calc = {sb, 8'hFF, 23'b0};
    end else if (sum == 28'd0) begin
      // Only two negative zeros produce a negative zero.
      calc = {sa & sb, 31'b0};
    end else if (e_fin >= 10'sd255) begin
      calc = {s_big, 8'hFF, 23'b0};
    end else if (e_fin <= 10'sd0) begin
      calc = {s_big, 31'b0};
    end else begin
      calc = {s_big, e_fin[7:0], frac};
    end
  end

  // Output register: update only on accepted operands, valid pulses per op.
  always_comb begin
    result_d    = in_valid ? calc : result_q;
    out_valid_d = in_valid;
  end

  // Registered result with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fpu_add_sub.sv
// Directed self-checking bench for fpu_add_sub with hand-computed vectors.
module tb_fpu_add_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        Add_nSub;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic        out_valid;

  int n_cmp;
  int n_err;

  fpu_add_sub dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .Add_nSub  (Add_nSub),
    .A         (A),
    .B         (B),
    .Result    (Result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operation at the falling edge, check result after the next rising edge.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                    input logic [31:0] exp, input string tag);
    @(negedge clk);
    A        = a;
    B        = b;
    Add_nSub = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check(tag, Result, exp);
    check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    Add_nSub = 1'b0;
    A        = '0;
    B        = '0;
    #3;
    check("rst_result", Result, 32'h0000_0000);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream: in_valid stays high across these.
    op(32'h3FC0_0000, 32'hC050_0000, 1'b0, 32'hBFE0_0000, "mixed_add");
    op(32'hC050_0000, 32'hC050_0000, 1'b0, 32'hC0D0_0000, "neg_same");
    op(32'h4050_0000, 32'h3FC0_0000, 1'b0, 32'h4098_0000, "pos_shift1");
    op(32'h4230_0000, 32'h43A4_0000, 1'b0, 32'h43BA_0000, "pos_shift3");
    op(32'h3FC0_0000, 32'h4050_0000, 1'b1, 32'hBFE0_0000, "sub_neg");
    op(32'h43A4_0000, 32'hC230_0000, 1'b1, 32'h43BA_0000, "sub_negb");
    op(32'h420F_0000, 32'h41A4_0000, 1'b1, 32'h4174_0000, "sub_norm");
    op(32'h420F_0000, 32'h31A4_0000, 1'b0, 32'h420F_0000, "tiny_lost");
    op(32'h420F_0000, 32'h41A4_0000, 1'b0, 32'h4261_0000, "add_align");
    op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, "inf_m_inf");
    op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "overflow");
    op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "exact_zero");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, "negzero_sum");
    op(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, "mixzero_sum");
    op(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, "nan_in");
    op(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, "inf_effsign");
    op(32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, "subn_flush");
    op(32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, "underflow");

    // Idle cycle: valid drops, result holds.
    @(negedge clk);
    in_valid = 1'b0;
    A        = 32'h4000_0000;
    B        = 32'h4000_0000;
    @(posedge clk);
    #1;
    check("idle_valid", {31'b0, out_valid}, 32'd0);
    check("idle_hold", Result, 32'h8000_0000);

    op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, "pre_reset");

    // Asynchronous reset mid-stream, with an operation waiting at the inputs.
    @(negedge clk);
    A        = 32'h4050_0000;
    B        = 32'h3FC0_0000;
    Add_nSub = 1'b0;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", Result, 32'h0000_0000);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_result", Result, 32'h0000_0000);
    check("arst_hold_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op(32'h4050_0000, 32'h3FC0_0000, 1'b0, 32'h4098_0000, "post_reset");

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final_valid", {31'b0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_add_sub.md
# fpu_add_sub

Single-precision (IEEE-754 binary32) floating-point adder/subtractor for the MIPS FPU datapath. It computes A+B or A−B selected by `Add_nSub`. The result is registered and delivered one clock after the operands are accepted. It feeds the MIPS floating-point register writeback path and the DSP peripherals.

## Interface
- No parameters.
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — operands valid; sampled on the rising edge of `clk`.
- `Add_nSub` in 1 — operation select: 0 = A+B, 1 = A−B.
- `A` in 32 — binary32 operand A.
- `B` in 32 — binary32 operand B.
- `Result` out 32 — binary32 result, registered.
- `out_valid` out 1 — one-cycle pulse: `Result` updated this cycle.

## Operation
- Effective sign of B is `B[31] ^ Add_nSub`.
- Operands are swapped so the larger magnitude is first; comparison is by exponent, then mantissa.
- Hidden bit is 1 for exponent ≠ 0.
- Smaller operand is right-shifted by the exponent difference into guard/round/sticky bits. Shifts ≥ 26 leave only sticky.
- Same effective signs: add the mantissas.
- Different effective signs: subtract smaller from larger; result sign is the sign of the larger operand.
- Normalise:
  - carry out → shift right 1, exponent +1;
  - otherwise leading-zero count → shift left, exponent −count.
- Round to 23 fraction bits (see Configuration). A rounding carry renormalises with exponent +1.
- Special cases, in priority order:
  - any NaN input, or inf − inf (effective) → `32'h7FC00000`;
  - an infinite input → that infinity, with its effective sign;
  - subnormal inputs → flushed to ±0 before the operation;
  - exact zero result → +0, except (−0)+(−0) → −0;
  - exponent overflow (≥255) → ±inf;
  - result below minimum normal → ±0, sign kept.

## Timing
- Latency is 1 cycle. When `in_valid`=1 at edge N, `Result` and `out_valid`=1 appear after edge N.
- Throughput is one operation per cycle; back-to-back `in_valid` is allowed. No backpressure and no busy state.
- `in_valid`=0 → `out_valid`=0 on the next cycle; `Result` holds its last value.
- Reset:
  - `Result`=32'h00000000 and `out_valid`=0 immediately on `rst_n` low, independent of `clk`;
  - an operation in flight is discarded;
  - the first `in_valid` edge after `rst_n` rises is processed normally.
- Inputs need only be stable around the sampling edge. There is no combinational path from inputs to outputs.

## Configuration
- `FPU_RNE_EN`
  - Defined: round-to-nearest, ties-to-even, using guard/round/sticky.
  - Undefined: round toward zero (truncation); guard/round/sticky discarded; overflow saturates to ±inf.
- All test values below are exact and identical in both modes, except the tiny-operand case. That case yields `420F0000` in both modes.

## Test plan
- Mixed-sign add: A=3FC00000 (1.5), B=C0500000 (−3.25), `Add_nSub`=0 → `Result`=BFE00000 (−1.75) one cycle later, `out_valid` pulse.
- Same-sign and exponent shift:
  - C0500000+C0500000 → C0D00000;
  - 40500000+3FC00000 → 40980000;
  - 42300000+43A40000 → 43BA0000.
- Subtract:
  - 3FC00000−40500000 → BFE00000;
  - 43A40000−C2300000 → 43BA0000;
  - 420F0000−41A40000 → 41740000.
- Alignment loss: 420F0000+31A40000 → 420F0000. Also 420F0000+41A40000 → 42610000.
- Specials:
  - 7F800000−7F800000 → 7FC00000;
  - 7F7FFFFF+7F7FFFFF → 7F800000;
  - 3F800000−3F800000 → 00000000.
- Control:
  - back-to-back vectors on consecutive cycles each produce results in order with `out_valid` held high;
  - asserting `rst_n`=0 mid-stream clears `Result` and `out_valid` asynchronously.
